// File: rtl/sysbus_pkg.sv
// Sysbus responder shared definitions:
// tag layout, line geometry and FSM states.
package sysbus_pkg;

  localparam int TAG_RW_BIT = 12;
  localparam logic TAG_READ = 1'b1;
  localparam logic TAG_WRITE = 1'b0;
  localparam int LINE_OFFSET_BITS = 6;

  typedef enum logic [2:0] {
    IDLE,
    HDR_ACK,
    WDATA,
    WAIT,
    RESP
  } sysbus_state_e;

endpackage

// File: rtl/sysbus_line_mem.sv
// Behavioural line store: word-addressed array with a
// registered read address and a synchronous write port.
module sysbus_line_mem #(
  parameter int DW = 64,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] raddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
    end else begin
      raddr_q <= raddr;
    end
  end

  // Contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr_q];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: acks headers, absorbs
// write beats, returns read lines after a fixed latency.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int BEATS = 8,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int IW = $clog2(DEPTH);
  localparam int BW = $clog2(BEATS);
  localparam int LW =
    (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  sysbus_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] lat_q, lat_d;
  logic mem_we;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_reqcyc) begin
          idx_d = bus_req[LINE_OFFSET_BITS+IW-1:
                          LINE_OFFSET_BITS];
          tag_d = bus_reqtag;
          beat_d = '0;
          state_d = HDR_ACK;
        end
      end
      HDR_ACK: begin
        beat_d = '0;
        unique case (tag_q[TAG_RW_BIT])
          TAG_WRITE: state_d = WDATA;
          TAG_READ: begin
            if (LATENCY == 0) begin
              state_d = RESP;
            end else begin
              state_d = WAIT;
              lat_d = LW'(LATENCY - 1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
      WDATA: begin
        if (bus_reqcyc) begin
          mem_we = 1'b1;
          if (beat_q == LAST) begin
            beat_d = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          beat_d = '0;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RESP: begin
        if (bus_respack) begin
          if (beat_q == LAST) begin
            beat_d = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    unique case (state_q)
      HDR_ACK: bus_reqack = 1'b1;
      WDATA:   bus_reqack = bus_reqcyc;
      RESP: begin
        bus_respcyc = 1'b1;
        bus_resp    = mem_rdata;
        bus_resptag = tag_q;
      end
      default: ;
    endcase
  end

  // Read address follows the next beat so data is
  // ready in the cycle the beat is presented.
  sysbus_line_mem #(
    .DW (BUS_DATA_WIDTH),
    .AW (IW + BW)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (mem_we),
    .waddr ({idx_q, beat_q}),
    .wdata (bus_req),
    .raddr ({idx_d, beat_d}),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: writes,
// reads, backpressure, stall, wrap, busy and reset.
module tb_sysbus_mem_responder;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int BEATS = 8;
  localparam int DEPTH = 1024;
  localparam int LATENCY = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic bus_reqack;
  logic bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic bus_respack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (DW),
    .BUS_TAG_WIDTH  (TW),
    .BEATS          (BEATS),
    .DEPTH          (DEPTH),
    .LATENCY        (LATENCY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic issue_hdr(input logic [63:0] addr,
                           input logic [TW-1:0] tag);
    @(negedge clk);
    bus_reqcyc = 1'b1;
    bus_req = addr;
    bus_reqtag = tag;
    @(negedge clk);
    bus_reqcyc = 1'b0;
    check("hdr_ack", bus_reqack, 1);
  endtask

  task automatic write_line(input logic [63:0] addr,
                            input logic [TW-1:0] tag,
                            input logic [63:0] base,
                            input bit stall);
    issue_hdr(addr, tag);
    @(negedge clk);
    check("w_gap_ack", bus_reqack, 0);
    for (int i = 0; i < BEATS; i++) begin
      bus_reqcyc = 1'b1;
      bus_req = base + 64'(i);
      #1 check("w_beat_ack", bus_reqack, 1);
      @(negedge clk);
      bus_reqcyc = 1'b0;
      if (stall && i == 2) begin
        repeat (2) begin
          #1 check("w_stall_ack", bus_reqack, 0);
          @(negedge clk);
        end
      end
    end
    #1 check("w_done_ack", bus_reqack, 0);
  endtask

  task automatic read_body(input logic [TW-1:0] tag,
                           input logic [63:0] base,
                           input int stall_beat,
                           input int rst_beat,
                           input bit busy,
                           input logic [63:0] baddr,
                           input logic [TW-1:0] btag);
    int cnt;
    cnt = 0;
    check("r_pre_cyc", bus_respcyc, 0);
    while (!bus_respcyc && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("r_latency", cnt, LATENCY + 1);
    for (int i = 0; i < BEATS; i++) begin
      check("r_cyc", bus_respcyc, 1);
      check("r_data", bus_resp, base + 64'(i));
      check("r_tag", bus_resptag, tag);
      if (busy && i == 1) begin
        bus_reqcyc = 1'b1;
        bus_req = baddr;
        bus_reqtag = btag;
      end
      if (busy && i >= 1) begin
        #1 check("busy_noack", bus_reqack, 0);
      end
      if (i == rst_beat) begin
        reset = 1'b0;
        #1;
        check("rst_respcyc", bus_respcyc, 0);
        check("rst_reqack", bus_reqack, 0);
        check("rst_resp", bus_resp, 0);
        check("rst_resptag", bus_resptag, 0);
        @(negedge clk);
        reset = 1'b1;
        break;
      end
      if (i == stall_beat) begin
        bus_respack = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_data", bus_resp, base + 64'(i));
          check("bp_cyc", bus_respcyc, 1);
        end
        bus_respack = 1'b1;
      end
      @(negedge clk);
    end
    if (rst_beat < 0) begin
      check("r_done_cyc", bus_respcyc, 0);
    end
  endtask

  initial begin
    bus_reqcyc = 1'b0;
    bus_req = '0;
    bus_reqtag = '0;
    bus_respack = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_reqack0", bus_reqack, 0);
    check("rst_respcyc0", bus_respcyc, 0);
    check("rst_resp0", bus_resp, 0);
    check("rst_resptag0", bus_resptag, 0);
    reset = 1'b1;

    write_line(64'h1000, 13'h0005, 64'h11, 1'b0);
    issue_hdr(64'h1000, 13'h1005);
    read_body(13'h1005, 64'h11, -1, -1, 1'b0, '0, '0);

    issue_hdr(64'h1000, 13'h1005);
    read_body(13'h1005, 64'h11, 2, -1, 1'b0, '0, '0);

    write_line(64'h2040, 13'h0006, 64'h21, 1'b1);
    issue_hdr(64'h2040, 13'h1006);
    read_body(13'h1006, 64'h21, -1, -1, 1'b0, '0, '0);

    write_line(64'h1000 + 64'(DEPTH * 64), 13'h0007,
               64'h31, 1'b0);
    issue_hdr(64'h1000, 13'h1008);
    read_body(13'h1008, 64'h31, -1, -1, 1'b0, '0, '0);

    issue_hdr(64'h1000, 13'h1009);
    read_body(13'h1009, 64'h31, -1, -1, 1'b1,
              64'h2040, 13'h100A);
    @(negedge clk);
    check("busy_hdr_ack", bus_reqack, 1);
    bus_reqcyc = 1'b0;
    read_body(13'h100A, 64'h21, -1, -1, 1'b0, '0, '0);

    issue_hdr(64'h2040, 13'h100B);
    read_body(13'h100B, 64'h21, -1, 4, 1'b0, '0, '0);
    issue_hdr(64'h1000, 13'h100C);
    read_body(13'h100C, 64'h31, -1, -1, 1'b0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Memory-side end of the Sysbus request/response protocol; serves line reads and writes issued by the core's bus arbiter.
- Holds a behavioural line memory, acknowledges request headers, absorbs write beats and returns read lines as tagged multi-beat responses after a programmable latency.
- Used as the memory model in core-level simulation and as the reference responder for cache and arbiter verification.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus_req / bus_resp.
- BUS_TAG_WIDTH, 13, width of request/response tags.
- BEATS, 8, data beats per line (64-byte line).
- DEPTH, 1024, number of lines held; power of two.
- LATENCY, 4, idle cycles between header ack and first read beat (0 allowed).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_reqcyc  in  1  request valid: header, or write beat while in WDATA.
- bus_req  in  BUS_DATA_WIDTH  byte address (header) or write data (beat).
- bus_reqtag  in  BUS_TAG_WIDTH  tag; bit 12 = 1 READ, 0 WRITE.
- bus_reqack  out  1  header/beat accepted.
- bus_respcyc  out  1  response beat valid.
- bus_resp  out  BUS_DATA_WIDTH  response data beat.
- bus_resptag  out  BUS_TAG_WIDTH  tag of the originating read.
- bus_respack  in  1  initiator accepts current response beat.

Behaviour:
- Reset (reset low, async): state IDLE; bus_reqack, bus_respcyc = 0; bus_resp, bus_resptag = 0; beat and latency counters = 0. Memory contents are not cleared.
- Line index = bus_req[6+log2(DEPTH)-1:6]. Low 6 bits are ignored. Upper bits are dropped, so the address wraps modulo DEPTH lines.
- State IDLE: on an edge with bus_reqcyc=1, latch index and tag, then go to HDR_ACK.
- State HDR_ACK: bus_reqack=1 for exactly one cycle. Next state: WDATA if tag[12]=0; RESP if READ and LATENCY=0; otherwise WAIT with counter=LATENCY-1.
- State WDATA: bus_reqack = bus_reqcyc (combinational).
  - On each edge with bus_reqcyc=1, store bus_req to word beat_cnt and increment beat_cnt.
  - After beat BEATS-1, return to IDLE. No response is sent for writes.
  - bus_reqcyc low stalls the transfer indefinitely.
- State WAIT: decrement counter each cycle; at 0, go to RESP with beat_cnt=0.
- State RESP: bus_respcyc=1, bus_resp = word beat_cnt, bus_resptag = latched tag.
  - The beat is held stable while bus_respack=0.
  - On an edge with bus_respack=1, advance the beat. After beat BEATS-1, go to IDLE and bus_respcyc drops the next cycle.
- bus_reqack is 0 in all states except HDR_ACK and WDATA.
- Requests arriving outside IDLE are ignored (no ack); the initiator holds them. bus_reqcyc still high in the cycle after HDR_ACK is not a new header.
- Read timing: header sampled at edge N → reqack in cycle N+1 → first respcyc in cycle N+2+LATENCY.
- A write followed by a read of the same line returns the written data (no hazard window, since transactions are serialized).
- Reset asserted mid-transaction: abort immediately. Partial write beats already stored remain in memory.

Decomposition:
- sysbus_pkg: tag field positions, READ=1'b1 / WRITE=1'b0 at bit 12, LINE_OFFSET_BITS=6, the state enum {IDLE, HDR_ACK, WDATA, WAIT, RESP}.
- One sub-module, sysbus_line_mem: a DEPTH×BEATS×64 array with registered-address word read port and synchronous word write port.
- FSM and counters live in the top module.

Test Plan:
- Write then read: write header addr 0x1000, tag 0x0005, beats 0x11..0x18; read addr 0x1000, tag 0x1005, respack held 1. Expected: reqack high one cycle after each header; respcyc first high 6 cycles after read header edge (LATENCY=4); beats 0x11..0x18 each with resptag 0x1005; IDLE after 8 beats.
- Backpressure: same read with respack low for 3 cycles on beat 2. Expected: bus_resp stays 0x13 and respcyc stays 1 throughout; 8 beats total, none duplicated or skipped.
- Write stall: drop reqcyc for 2 cycles after beat 3 of a write to 0x2040. Expected: reqack low during the gap; a readback of 0x2040 returns beats in order.
- Address wrap: write line at 0x1000 + DEPTH*64, read 0x1000. Expected: the same data.
- Busy request: issue a second header while in RESP. Expected: no reqack until IDLE; the second header is then serviced.
- Async reset: reset low for 1 cycle during read beat 4. Expected: respcyc, reqack, resp and resptag go to 0 immediately; the next read completes normally.
